// File: rtl/dp_ram_be.sv
// True dual-port synchronous RAM with per-byte write enables, selectable read-during-write,
// fixed cross-port write priority, optional output register and optional post-reset clear.
//
// state | meaning
// CLEAR | zeroing memory one word per cycle; port requests ignored
// RUN   | normal dual-port operation
module dp_ram_be #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 6,
    parameter int BYTE_W     = 8,
    parameter int RDW_MODE   = 0,
    parameter int COLL_PRIO  = 0,
    parameter int OUT_REG    = 0,
    parameter int INIT_CLEAR = 1
) (
    input  logic                           clk,
    input  logic                           rst,
    output logic                           busy,
    output logic                           collision,
    input  logic                           enA,
    input  logic [DATA_WIDTH/BYTE_W-1:0]   weA,
    input  logic [ADDR_WIDTH-1:0]          addrA,
    input  logic [DATA_WIDTH-1:0]          dinA,
    output logic [DATA_WIDTH-1:0]          doutA,
    output logic                           validA,
    input  logic                           enB,
    input  logic [DATA_WIDTH/BYTE_W-1:0]   weB,
    input  logic [ADDR_WIDTH-1:0]          addrB,
    input  logic [DATA_WIDTH-1:0]          dinB,
    output logic [DATA_WIDTH-1:0]          doutB,
    output logic                           validB
);
    localparam int NB    = DATA_WIDTH / BYTE_W;
    localparam int DEPTH = 2 ** ADDR_WIDTH;

    typedef enum logic {CLEAR, RUN} state_t;

    state_t                  state, state_nxt;
    logic [ADDR_WIDTH-1:0]   clr_addr;
    logic [DATA_WIDTH-1:0]   mem [DEPTH];

    logic                    acc_a, acc_b, same, coll;
    logic [NB-1:0]           lane_a, lane_b;
    logic [DATA_WIDTH-1:0]   old_a, old_b, new_a, new_b, rd_a, rd_b;

    logic                    v1a, v1b, c1;
    logic [DATA_WIDTH-1:0]   d1a, d1b;

    always_ff @(posedge clk) begin
        if (rst) state <= (INIT_CLEAR != 0) ? CLEAR : RUN;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            CLEAR:   if (clr_addr == ADDR_WIDTH'(DEPTH - 1)) state_nxt = RUN;
            RUN:     state_nxt = RUN;
            default: state_nxt = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst)                 clr_addr <= '0;
        else if (state == CLEAR) clr_addr <= clr_addr + 1'b1;
    end

    assign busy  = (state == CLEAR);
    assign acc_a = enA && !rst && (state == RUN);
    assign acc_b = enB && !rst && (state == RUN);
    assign same  = (addrA == addrB);
    assign old_a = mem[addrA];
    assign old_b = mem[addrB];
    assign coll  = acc_a && acc_b && same && ((|weA) || (|weB));

    // On a same-address overlap the losing port drops its lane, so both merged
    // words below describe the same final memory word.
    always_comb begin
        lane_a = '0;
        lane_b = '0;
        new_a  = old_a;
        new_b  = old_b;
        for (int i = 0; i < NB; i++) begin
            lane_a[i] = acc_a && weA[i] && !(acc_b && same && weB[i] && (COLL_PRIO != 0));
            lane_b[i] = acc_b && weB[i] && !(acc_a && same && weA[i] && (COLL_PRIO == 0));
        end
        for (int i = 0; i < NB; i++) begin
            if (lane_a[i])              new_a[i*BYTE_W +: BYTE_W] = dinA[i*BYTE_W +: BYTE_W];
            else if (same && lane_b[i]) new_a[i*BYTE_W +: BYTE_W] = dinB[i*BYTE_W +: BYTE_W];
            if (lane_b[i])              new_b[i*BYTE_W +: BYTE_W] = dinB[i*BYTE_W +: BYTE_W];
            else if (same && lane_a[i]) new_b[i*BYTE_W +: BYTE_W] = dinA[i*BYTE_W +: BYTE_W];
        end
    end

    assign rd_a = (RDW_MODE == 0) ? new_a : old_a;
    assign rd_b = (RDW_MODE == 0) ? new_b : old_b;

    always_ff @(posedge clk) begin
        if (!rst && state == CLEAR) begin
            mem[clr_addr] <= '0;
        end else begin
            if (|lane_a) mem[addrA] <= new_a;
            if (|lane_b) mem[addrB] <= new_b;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v1a <= 1'b0;
            v1b <= 1'b0;
            c1  <= 1'b0;
            d1a <= '0;
            d1b <= '0;
        end else begin
            v1a <= acc_a;
            v1b <= acc_b;
            c1  <= coll;
            if (acc_a) d1a <= rd_a;
            if (acc_b) d1b <= rd_b;
        end
    end

    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic                  v2a, v2b, c2;
            logic [DATA_WIDTH-1:0] d2a, d2b;

            always_ff @(posedge clk) begin
                if (rst) begin
                    v2a <= 1'b0;
                    v2b <= 1'b0;
                    c2  <= 1'b0;
                    d2a <= '0;
                    d2b <= '0;
                end else begin
                    v2a <= v1a;
                    v2b <= v1b;
                    c2  <= c1;
                    if (v1a) d2a <= d1a;
                    if (v1b) d2b <= d1b;
                end
            end

            assign validA    = v2a;
            assign validB    = v2b;
            assign doutA     = d2a;
            assign doutB     = d2b;
            assign collision = c2;
        end else begin : g_no_out_reg
            assign validA    = v1a;
            assign validB    = v1b;
            assign doutA     = d1a;
            assign doutB     = d1b;
            assign collision = c1;
        end
    endgenerate
endmodule

// File: tb/tb_dp_ram_be.sv
// Bench for dp_ram_be: two instances (write-first/prio A/no out reg and read-first/prio B/out reg)
// share one stimulus stream and are compared every cycle against a word-level memory model.
module tb_dp_ram_be;
    localparam int DW    = 32;
    localparam int AW    = 4;
    localparam int NB    = 4;
    localparam int DEPTH = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, enA, enB;
    logic [NB-1:0] weA, weB;
    logic [AW-1:0] addrA, addrB;
    logic [DW-1:0] dinA, dinB;

    logic          busy0, coll0, vA0, vB0, busy1, coll1, vA1, vB1;
    logic [DW-1:0] dA0, dB0, dA1, dB1;

    dp_ram_be #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BYTE_W(8), .RDW_MODE(0),
                .COLL_PRIO(0), .OUT_REG(0), .INIT_CLEAR(1)) u0 (
        .clk(clk), .rst(rst), .busy(busy0), .collision(coll0),
        .enA(enA), .weA(weA), .addrA(addrA), .dinA(dinA), .doutA(dA0), .validA(vA0),
        .enB(enB), .weB(weB), .addrB(addrB), .dinB(dinB), .doutB(dB0), .validB(vB0));

    dp_ram_be #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BYTE_W(8), .RDW_MODE(1),
                .COLL_PRIO(1), .OUT_REG(1), .INIT_CLEAR(1)) u1 (
        .clk(clk), .rst(rst), .busy(busy1), .collision(coll1),
        .enA(enA), .weA(weA), .addrA(addrA), .dinA(dinA), .doutA(dA1), .validA(vA1),
        .enB(enB), .weB(weB), .addrB(addrB), .dinB(dinB), .doutB(dB1), .validB(vB1));

    int n_cmp = 0;
    int n_err = 0;

    // Model: one memory image per instance, since the priority differs between them.
    logic [DW-1:0] mm [2][DEPTH];
    int            clr_left = 0;
    logic [DW-1:0] edA [2], edB [2];
    logic          evA [2], evB [2], ecol [2];
    logic          pvA = 1'b0, pvB = 1'b0, pcol = 1'b0;
    logic [DW-1:0] pdA = '0, pdB = '0;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chkb(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    function automatic void wr(input int d, input logic [AW-1:0] a, input logic [NB-1:0] we,
                               input logic [DW-1:0] din);
        for (int i = 0; i < NB; i++)
            if (we[i]) mm[d][a][i*8 +: 8] = din[i*8 +: 8];
    endfunction

    task automatic step(input logic r,
                        input logic ea, input logic [NB-1:0] wa, input logic [AW-1:0] aa, input logic [DW-1:0] da,
                        input logic eb, input logic [NB-1:0] wb, input logic [AW-1:0] ab, input logic [DW-1:0] db);
        logic [DW-1:0] rdA [2];
        logic [DW-1:0] rdB [2];
        logic [DW-1:0] bA, bB;
        logic          reqA, reqB, cl;
        rst = r; enA = ea; weA = wa; addrA = aa; dinA = da;
        enB = eb; weB = wb; addrB = ab; dinB = db;
        reqA = 1'b0; reqB = 1'b0; cl = 1'b0;
        rdA[0] = '0; rdA[1] = '0; rdB[0] = '0; rdB[1] = '0;
        if (r) begin
            clr_left = DEPTH;
            for (int d = 0; d < 2; d++) begin
                evA[d] = 1'b0; evB[d] = 1'b0; ecol[d] = 1'b0; edA[d] = '0; edB[d] = '0;
            end
            pvA = 1'b0; pvB = 1'b0; pcol = 1'b0;
        end else begin
            if (clr_left > 0) begin
                for (int d = 0; d < 2; d++) mm[d][DEPTH - clr_left] = '0;
                clr_left--;
            end else begin
                reqA = ea; reqB = eb;
                cl   = ea && eb && (aa == ab) && ((wa | wb) != 0);
                for (int d = 0; d < 2; d++) begin
                    bA = mm[d][aa];
                    bB = mm[d][ab];
                    // The priority port is applied last so it owns overlapping lanes.
                    if (d == 0) begin
                        if (eb) wr(d, ab, wb, db);
                        if (ea) wr(d, aa, wa, da);
                    end else begin
                        if (ea) wr(d, aa, wa, da);
                        if (eb) wr(d, ab, wb, db);
                    end
                    rdA[d] = (d == 0) ? mm[d][aa] : bA;
                    rdB[d] = (d == 0) ? mm[d][ab] : bB;
                end
            end
            evA[0] = reqA; evB[0] = reqB; ecol[0] = cl;
            if (reqA) edA[0] = rdA[0];
            if (reqB) edB[0] = rdB[0];
            evA[1] = pvA; evB[1] = pvB; ecol[1] = pcol;
            if (pvA) edA[1] = pdA;
            if (pvB) edB[1] = pdB;
            pvA = reqA; pvB = reqB; pcol = cl; pdA = rdA[1]; pdB = rdB[1];
        end
        @(posedge clk);
        #1;
        chkb("busy0", busy0, clr_left > 0);
        chkb("busy1", busy1, clr_left > 0);
        chkb("coll0", coll0, ecol[0]);
        chkb("coll1", coll1, ecol[1]);
        chkb("validA0", vA0, evA[0]);
        chkb("validB0", vB0, evB[0]);
        chkb("validA1", vA1, evA[1]);
        chkb("validB1", vB1, evB[1]);
        chk("doutA0", dA0, edA[0]);
        chk("doutB0", dB0, edB[0]);
        chk("doutA1", dA1, edA[1]);
        chk("doutB1", dB1, edB[1]);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic rand_steps(input int n);
        logic [AW-1:0] aa, ab;
        for (int i = 0; i < n; i++) begin
            aa = ($urandom_range(0, 1) == 0) ? AW'($urandom_range(0, 3)) : AW'($urandom);
            ab = ($urandom_range(0, 1) == 0) ? AW'($urandom_range(0, 3)) : AW'($urandom);
            step(0, $urandom_range(0, 3) != 0, NB'($urandom), aa, $urandom,
                    $urandom_range(0, 3) != 0, NB'($urandom), ab, $urandom);
        end
    endtask

    initial begin
        step(1, 0, 0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(15);
        // Last busy cycle: addr 0 is already cleared, so a write that got through would stick.
        step(0, 1, 4'hF, 4'd0, 32'hFFFF_FFFF, 1, 4'hF, 4'd1, 32'h1234_5678);
        chkb("busy_end", busy0, 1'b0);
        for (int a = 0; a < DEPTH; a++)
            step(0, 1, 4'h0, AW'(a), 0, 1, 4'h0, AW'(DEPTH - 1 - a), 0);
        idle(2);

        step(0, 1, 4'hF, 4'd3, 32'hDEAD_BEEF, 0, 0, 0, 0);
        step(0, 1, 4'h1, 4'd3, 32'h0000_00AA, 0, 0, 0, 0);
        step(0, 1, 4'h0, 4'd3, 0, 0, 0, 0, 0);
        chk("byte_merge", dA0, 32'hDEAD_BEAA);
        idle(2);

        step(0, 1, 4'hF, 4'd5, 32'h1111_1111, 0, 0, 0, 0);
        step(0, 1, 4'hF, 4'd5, 32'h2222_2222, 0, 0, 0, 0);
        chk("rdw_write_first", dA0, 32'h2222_2222);
        idle(1);
        chk("rdw_read_first", dA1, 32'h1111_1111);
        idle(1);

        step(0, 1, 4'b0011, 4'd7, 32'hAAAA_AAAA, 1, 4'b0110, 4'd7, 32'hBBBB_BBBB);
        chkb("coll_ww0", coll0, 1'b1);
        idle(1);
        chkb("coll_pulse0", coll0, 1'b0);
        chkb("coll_ww1", coll1, 1'b1);
        step(0, 1, 4'h0, 4'd7, 0, 0, 0, 0, 0);
        chk("prio_a_word", dA0, 32'h00BB_AAAA);
        idle(1);
        chk("prio_b_word", dA1, 32'h00BB_BBAA);
        idle(1);

        step(0, 1, 4'hF, 4'd9, 32'h0BAD_F00D, 0, 0, 0, 0);
        step(0, 1, 4'h0, 4'd9, 0, 1, 4'hF, 4'd9, 32'h1234_5678);
        chk("xport_wf", dA0, 32'h1234_5678);
        chkb("coll_rw0", coll0, 1'b1);
        idle(1);
        chk("xport_rf", dA1, 32'h0BAD_F00D);
        step(0, 1, 4'h0, 4'd9, 0, 1, 4'h0, 4'd9, 0);
        chkb("coll_rr0", coll0, 1'b0);
        idle(1);
        chkb("coll_rr1", coll1, 1'b0);
        idle(1);

        rand_steps(400);
        idle(2);

        for (int a = 0; a < 8; a++) step(0, 1, 4'h0, AW'(a), 0, 0, 0, 0, 0);
        idle(3);
        for (int a = 0; a < 4; a++) step(0, 1, 4'h0, AW'(a), 0, 1, 4'h0, AW'(a + 4), 0);
        step(1, 1, 4'h0, 4'd4, 0, 1, 4'h0, 4'd5, 0);
        chkb("rst_flush_vA1", vA1, 1'b0);
        chkb("rst_flush_vA0", vA0, 1'b0);
        idle(6);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(16);
        rand_steps(150);
        idle(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
